// File: rtl/fetch.sv
// LC-3b instruction fetch stage: owns the fetch PC, issues word reads,
// buffers returned words in a small FIFO and presents them to decode.
module fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  output logic [15:0] npc,
  output logic [15:0] ir,
  output logic        valid
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DISCARD
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   req_addr_q, req_addr_d;
  logic [15:0]   tgt_q, tgt_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]   npc_mem_q [DEPTH];
  logic [15:0]   ir_mem_q  [DEPTH];

  logic [15:0]   rpc;
  logic [15:0]   req_next;
  logic          pop;
  logic          push;
  logic          flush;
  logic [CW-1:0] cnt_pop;
  logic [CW-1:0] cnt_push_pop;

  assign rpc          = {redirect_pc[15:1], 1'b0};
  assign req_next     = req_addr_q + 16'd2;
  assign valid        = (count_q != '0);
  assign pop          = valid & ~stall & ~redirect;
  assign push         = (state_q == FETCH) & imem_resp & ~redirect;
  assign cnt_pop      = count_q - CW'(pop);
  assign cnt_push_pop = count_q + CW'(1) - CW'(pop);

  assign imem_read    = (state_q == FETCH) | (state_q == DISCARD);
  // req_addr is left untouched on a redirect that enters DISCARD,
  // so it still names the read that is in flight.
  assign imem_address = req_addr_q;

  assign npc = npc_mem_q[rd_ptr_q];
  assign ir  = ir_mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    tgt_d      = tgt_q;
    flush      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          flush      = 1'b1;
          req_addr_d = rpc;
          state_d    = FETCH;
        end else if (cnt_pop < FULL) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (redirect && imem_resp) begin
          flush      = 1'b1;
          req_addr_d = rpc;
        end else if (redirect) begin
          flush   = 1'b1;
          tgt_d   = rpc;
          state_d = DISCARD;
        end else if (imem_resp) begin
          req_addr_d = req_next;
          if (cnt_push_pop >= FULL) begin
            state_d = IDLE;
          end
        end
      end
      DISCARD: begin
        if (redirect) begin
          flush = 1'b1;
          tgt_d = rpc;
        end
        if (imem_resp) begin
          req_addr_d = redirect ? rpc : tgt_q;
          state_d    = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = wr_ptr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      req_addr_q <= RESET_PC;
      tgt_q      <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      tgt_q      <= tgt_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        npc_mem_q[i] <= '0;
        ir_mem_q[i]  <= '0;
      end
    end else if (push) begin
      npc_mem_q[wr_ptr_q] <= req_next;
      ir_mem_q[wr_ptr_q]  <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed scenarios plus a randomized phase, checked
// against an in-order instruction-stream model of what decode should see.
module tb_fetch;

  localparam logic [15:0] RPC = 16'h3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_read;
  logic [15:0] imem_address;
  logic        imem_resp;
  logic [15:0] imem_rdata;
  logic [15:0] npc;
  logic [15:0] ir;
  logic        valid;

  int checks = 0;
  int failures = 0;

  int          lat;
  int          wcnt;
  bit          rnd_mem;
  logic [15:0] exp_addr;
  logic        s_valid, s_read, s_resp;
  logic [15:0] s_npc, s_ir, s_addr;
  logic        p_valid, p_stall, p_redir;
  logic [15:0] p_npc, p_ir;
  logic        pend;
  logic [15:0] pend_addr;
  bit          found;

  fetch #(.RESET_PC(RPC), .DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .npc          (npc),
    .ir           (ir),
    .valid        (valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem(input logic [15:0] a);
    return 16'h1000 + a;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample outputs, answer memory, drive decode-side
  // inputs and advance the expected instruction stream.
  task automatic cyc(input logic st, input logic rd, input logic [15:0] rp);
    @(negedge clk);
    s_valid = valid;
    s_npc   = npc;
    s_ir    = ir;
    s_read  = imem_read;
    s_addr  = imem_address;
    if (p_redir) begin
      chk1("valid_after_redirect", s_valid, 1'b0);
    end else if (p_stall && p_valid) begin
      chk1("stall_hold_valid", s_valid, 1'b1);
      chk("stall_hold_npc", s_npc, p_npc);
      chk("stall_hold_ir", s_ir, p_ir);
    end
    if (pend) begin
      chk1("read_held", s_read, 1'b1);
      chk("addr_stable", s_addr, pend_addr);
    end
    s_resp = 1'b0;
    if (s_read) begin
      if (rnd_mem) s_resp = ($urandom_range(0, 1) == 1);
      else if (wcnt >= lat) s_resp = 1'b1;
      if (s_resp) wcnt = 0;
      else wcnt++;
    end else begin
      wcnt = 0;
    end
    imem_resp   = s_resp;
    imem_rdata  = s_resp ? mem(s_addr) : 16'hDEAD;
    stall       = st;
    redirect    = rd;
    redirect_pc = rp;
    pend        = s_read && !s_resp;
    pend_addr   = s_addr;
    #1;
    chk1("no_push_when_full", dut.push && (dut.count_q == 2'd2), 1'b0);
    if (s_valid && !st && !rd) begin
      chk("pop_npc", s_npc, exp_addr + 16'd2);
      chk("pop_ir", s_ir, mem(exp_addr));
      exp_addr = exp_addr + 16'd2;
    end
    if (rd) exp_addr = {rp[15:1], 1'b0};
    p_valid = s_valid;
    p_stall = st;
    p_redir = rd;
    p_npc   = s_npc;
    p_ir    = s_ir;
  endtask

  task automatic do_reset(input int l);
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    imem_resp   = 1'b0;
    imem_rdata  = 16'h0000;
    lat         = l;
    wcnt        = 0;
    pend        = 1'b0;
    p_valid     = 1'b0;
    p_stall     = 1'b0;
    p_redir     = 1'b0;
    exp_addr    = RPC;
    #1;
    chk1("rst_read", imem_read, 1'b0);
    chk("rst_addr", imem_address, RPC);
    chk1("rst_valid", valid, 1'b0);
    chk("rst_npc", npc, 16'h0000);
    chk("rst_ir", ir, 16'h0000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    rnd_mem = 1'b0;
    do_reset(0);

    // zero-wait streaming after reset
    cyc(1'b0, 1'b0, 16'h0);
    chk1("first_read", s_read, 1'b1);
    chk("first_addr", s_addr, 16'h3000);
    chk1("first_cycle_valid", s_valid, 1'b0);
    cyc(1'b0, 1'b0, 16'h0);
    chk1("first_valid", s_valid, 1'b1);
    chk("first_npc", s_npc, 16'h3002);
    chk("first_ir", s_ir, 16'h4000);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 16'h0);
      chk1("stream_valid", s_valid, 1'b1);
      chk("stream_npc", s_npc, 16'(16'h3004 + 2 * i));
      chk("stream_ir", s_ir, 16'(16'h4002 + 2 * i));
    end

    // redirect together with response and a would-be pop
    cyc(1'b0, 1'b1, 16'h0500);
    chk1("same_cyc_valid", s_valid, 1'b1);
    chk1("same_cyc_resp", s_resp, 1'b1);
    cyc(1'b0, 1'b0, 16'h0);
    chk1("same_cyc_empty", s_valid, 1'b0);
    chk1("same_cyc_read", s_read, 1'b1);
    chk("same_cyc_addr", s_addr, 16'h0500);
    cyc(1'b0, 1'b0, 16'h0);
    chk("same_cyc_npc", s_npc, 16'h0502);
    chk("same_cyc_ir", s_ir, 16'h1500);

    // address wrap with odd redirect target
    cyc(1'b0, 1'b1, 16'hFFFD);
    cyc(1'b0, 1'b0, 16'h0);
    chk("wrap_addr0", s_addr, 16'hFFFC);
    chk1("wrap_valid0", s_valid, 1'b0);
    cyc(1'b0, 1'b0, 16'h0);
    chk("wrap_addr1", s_addr, 16'hFFFE);
    chk("wrap_npc1", s_npc, 16'hFFFE);
    chk("wrap_ir1", s_ir, 16'h0FFC);
    cyc(1'b0, 1'b0, 16'h0);
    chk("wrap_addr2", s_addr, 16'h0000);
    chk("wrap_npc2", s_npc, 16'h0000);
    chk("wrap_ir2", s_ir, 16'h0FFE);

    // stall for 5 cycles from the first valid entry
    do_reset(0);
    cyc(1'b0, 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 16'h0);
    chk1("stall_first_valid", s_valid, 1'b1);
    chk("stall_head_npc", s_npc, 16'h3002);
    chk("stall_head_ir", s_ir, 16'h4000);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 16'h0);
      chk1("stall_full_idle", s_read, 1'b0);
      chk("stall_npc", s_npc, 16'h3002);
      chk("stall_ir", s_ir, 16'h4000);
    end
    cyc(1'b0, 1'b0, 16'h0);
    chk1("release_read", s_read, 1'b0);
    cyc(1'b0, 1'b0, 16'h0);
    chk1("resume_read", s_read, 1'b1);
    chk("resume_addr", s_addr, 16'h3004);
    chk("drain_npc", s_npc, 16'h3004);
    chk("drain_ir", s_ir, 16'h4002);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 16'h0);

    // 3-cycle memory, redirect while the 3004 read is outstanding
    do_reset(3);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1'b0, 1'b0, 16'h0);
      if (s_read && s_addr == 16'h3004) found = 1'b1;
    end
    chk1("found_3004", found, 1'b1);
    cyc(1'b0, 1'b1, 16'h0200);
    chk("disc_redirect_addr", s_addr, 16'h3004);
    chk1("disc_redirect_resp", s_resp, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      cyc(1'b0, 1'b0, 16'h0);
      chk1("disc_read", s_read, 1'b1);
      chk("disc_addr", s_addr, 16'h3004);
      chk1("disc_valid", s_valid, 1'b0);
      if (s_resp) found = 1'b1;
    end
    chk1("disc_resp_seen", found, 1'b1);
    cyc(1'b0, 1'b0, 16'h0);
    chk1("tgt_read", s_read, 1'b1);
    chk("tgt_addr", s_addr, 16'h0200);
    chk1("tgt_valid", s_valid, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc(1'b0, 1'b0, 16'h0);
      if (s_valid) found = 1'b1;
    end
    chk1("tgt_valid_seen", found, 1'b1);
    chk("tgt_npc", s_npc, 16'h0202);
    chk("tgt_ir", s_ir, 16'h1200);

    // enter DISCARD, then reset mid-cycle
    cyc(1'b0, 1'b1, 16'h0800);
    cyc(1'b0, 1'b0, 16'h0);
    chk1("pre_rst_read", s_read, 1'b1);
    chk("pre_rst_addr", s_addr, 16'h0202);
    do_reset(3);
    cyc(1'b0, 1'b0, 16'h0);
    chk1("restart_read", s_read, 1'b1);
    chk("restart_addr", s_addr, 16'h3000);
    chk1("restart_valid", s_valid, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc(1'b0, 1'b0, 16'h0);
      if (s_valid) found = 1'b1;
    end
    chk1("restart_valid_seen", found, 1'b1);
    chk("restart_npc", s_npc, 16'h3002);
    chk("restart_ir", s_ir, 16'h4000);

    // randomized stall/redirect/memory timing
    rnd_mem = 1'b1;
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
          16'($urandom));
    end
    rnd_mem = 1'b0;
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
